// File: rtl/umi_pkg.sv
// Shared constants and types for the UMI packet codec.
// Opcode encodings, atomic type codes and single-word field layout.
package umi_pkg;

    localparam int OPW = 8;
    localparam int SZW = 4;
    localparam int USW = 20;
    localparam int CW  = 32;

    localparam int OFF_CMD    = 0;
    localparam int OFF_DST_LO = 32;
    localparam int OFF_SRC_LO = 64;
    localparam int OFF_DATA0  = 96;
    localparam int OFF_DATA1  = 128;
    localparam int OFF_DST_HI = 160;
    localparam int OFF_SRC_HI = 192;
    localparam int OFF_DATA2  = 224;

    localparam logic [3:0] CLS_READ   = 4'b0010;
    localparam logic [3:0] CLS_ATOMIC = 4'b0100;

    localparam logic [2:0] WR_NORMAL   = 3'd0;
    localparam logic [2:0] WR_RESPONSE = 3'd1;
    localparam logic [2:0] WR_SIGNAL   = 3'd2;
    localparam logic [2:0] WR_STREAM   = 3'd3;
    localparam logic [2:0] WR_ACK      = 3'd4;

    localparam logic [3:0] AT_SWAP = 4'd0;
    localparam logic [3:0] AT_ADD  = 4'd1;
    localparam logic [3:0] AT_AND  = 4'd2;
    localparam logic [3:0] AT_OR   = 4'd3;
    localparam logic [3:0] AT_XOR  = 4'd4;
    localparam logic [3:0] AT_MIN  = 4'd5;
    localparam logic [3:0] AT_MAX  = 4'd6;

    typedef struct packed {
        logic write;
        logic read;
        logic atomic;
        logic invalid;
        logic wr_normal;
        logic wr_response;
        logic wr_signal;
        logic wr_stream;
        logic wr_ack;
        logic at_swap;
        logic at_add;
        logic at_and;
        logic at_or;
        logic at_xor;
        logic at_min;
        logic at_max;
    } umi_flags_t;

    function automatic logic [CW-1:0] cmd_word(
        input logic [USW-1:0] user,
        input logic [SZW-1:0] size,
        input logic [OPW-1:0] opcode
    );
        return {user, size, opcode};
    endfunction

endpackage

// File: rtl/umi_decode.sv
// Combinational UMI opcode decoder producing one-hot class/subtype flags.
module umi_decode
    import umi_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output umi_flags_t     flags
);

    logic is_write;
    logic is_read;
    logic is_atomic;

    assign is_write  = opcode[0];
    assign is_read   = (opcode[3:0] == CLS_READ);
    assign is_atomic = (opcode[3:0] == CLS_ATOMIC);

    always_comb begin
        flags        = '0;
        flags.write  = is_write;
        flags.read   = is_read;
        flags.atomic = is_atomic;
        if (is_write) begin
            case (opcode[3:1])
                WR_NORMAL:   flags.wr_normal   = 1'b1;
                WR_RESPONSE: flags.wr_response = 1'b1;
                WR_SIGNAL:   flags.wr_signal   = 1'b1;
                WR_STREAM:   flags.wr_stream   = 1'b1;
                WR_ACK:      flags.wr_ack      = 1'b1;
                default:     flags.invalid     = 1'b1;
            endcase
        end
        if (is_atomic) begin
            case (opcode[7:4])
                AT_SWAP: flags.at_swap = 1'b1;
                AT_ADD:  flags.at_add  = 1'b1;
                AT_AND:  flags.at_and  = 1'b1;
                AT_OR:   flags.at_or   = 1'b1;
                AT_XOR:  flags.at_xor  = 1'b1;
                AT_MIN:  flags.at_min  = 1'b1;
                AT_MAX:  flags.at_max  = 1'b1;
                default: flags.invalid = 1'b1;
            endcase
        end
        if (!is_write && !is_read && !is_atomic) begin
            flags.invalid = 1'b1;
        end
    end

endmodule

// File: rtl/umi_packet_codec.sv
// Registered single-word UMI packet codec with independent pack and
// unpack paths, each one cycle of latency.
module umi_packet_codec
    import umi_pkg::*;
#(
    parameter int AW = 64,
    parameter int UW = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic [SZW-1:0] size,
    input  logic [USW-1:0] user,
    input  logic           burst,
    input  logic [AW-1:0]  dstaddr,
    input  logic [AW-1:0]  srcaddr,
    input  logic [UW-1:0]  data,
    output logic [UW-1:0]  packet_out,
    input  logic [UW-1:0]  packet_in,
    output logic [UW-1:0]  u_data,
    output logic [AW-1:0]  u_dstaddr,
    output logic [AW-1:0]  u_srcaddr,
    output logic [OPW-1:0] cmd_opcode,
    output logic [SZW-1:0] cmd_size,
    output logic [USW-1:0] cmd_user,
    output logic           cmd_write,
    output logic           cmd_read,
    output logic           cmd_atomic,
    output logic           cmd_invalid,
    output logic           cmd_write_normal,
    output logic           cmd_write_response,
    output logic           cmd_write_signal,
    output logic           cmd_write_stream,
    output logic           cmd_write_ack,
    output logic           cmd_atomic_swap,
    output logic           cmd_atomic_add,
    output logic           cmd_atomic_and,
    output logic           cmd_atomic_or,
    output logic           cmd_atomic_xor,
    output logic           cmd_atomic_min,
    output logic           cmd_atomic_max
);

    logic [UW-1:0] pack;
    umi_flags_t    flags_d;
    umi_flags_t    flags_q;

    // Addresses are split lo/hi around the first two data words.
    always_comb begin
        pack = '0;
        if (burst) begin
            pack = data;
        end else begin
            pack[OFF_CMD +: CW]    = cmd_word(user, size, opcode);
            pack[OFF_DST_LO +: 32] = dstaddr[31:0];
            pack[OFF_SRC_LO +: 32] = srcaddr[31:0];
            pack[OFF_DATA0 +: 32]  = data[31:0];
            pack[OFF_DATA1 +: 32]  = data[63:32];
            pack[OFF_DST_HI +: 32] = dstaddr[63:32];
            pack[OFF_SRC_HI +: 32] = srcaddr[63:32];
            pack[OFF_DATA2 +: 32]  = data[95:64];
        end
    end

    umi_decode u_decode (
        .opcode (packet_in[OPW-1:0]),
        .flags  (flags_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            packet_out <= '0;
            u_data     <= '0;
            u_dstaddr  <= '0;
            u_srcaddr  <= '0;
            cmd_opcode <= '0;
            cmd_size   <= '0;
            cmd_user   <= '0;
            flags_q    <= '0;
        end else begin
            packet_out <= pack;
            u_data     <= {{(UW-96){1'b0}},
                           packet_in[OFF_DATA2 +: 32],
                           packet_in[OFF_DATA1 +: 32],
                           packet_in[OFF_DATA0 +: 32]};
            u_dstaddr  <= {packet_in[OFF_DST_HI +: 32],
                           packet_in[OFF_DST_LO +: 32]};
            u_srcaddr  <= {packet_in[OFF_SRC_HI +: 32],
                           packet_in[OFF_SRC_LO +: 32]};
            cmd_opcode <= packet_in[OPW-1:0];
            cmd_size   <= packet_in[OPW +: SZW];
            cmd_user   <= packet_in[OPW+SZW +: USW];
            flags_q    <= flags_d;
        end
    end

    assign cmd_write          = flags_q.write;
    assign cmd_read           = flags_q.read;
    assign cmd_atomic         = flags_q.atomic;
    assign cmd_invalid        = flags_q.invalid;
    assign cmd_write_normal   = flags_q.wr_normal;
    assign cmd_write_response = flags_q.wr_response;
    assign cmd_write_signal   = flags_q.wr_signal;
    assign cmd_write_stream   = flags_q.wr_stream;
    assign cmd_write_ack      = flags_q.wr_ack;
    assign cmd_atomic_swap    = flags_q.at_swap;
    assign cmd_atomic_add     = flags_q.at_add;
    assign cmd_atomic_and     = flags_q.at_and;
    assign cmd_atomic_or      = flags_q.at_or;
    assign cmd_atomic_xor     = flags_q.at_xor;
    assign cmd_atomic_min     = flags_q.at_min;
    assign cmd_atomic_max     = flags_q.at_max;

endmodule

// File: tb/tb_umi_packet_codec.sv
// Self-checking bench for umi_packet_codec: decode vector table with
// scoreboard plus hand sequences for layout, loopback, burst and reset.
module tb_umi_packet_codec;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   opcode;
    logic [3:0]   size;
    logic [19:0]  user;
    logic         burst;
    logic [63:0]  dstaddr;
    logic [63:0]  srcaddr;
    logic [255:0] data;
    logic [255:0] packet_out;
    logic [255:0] packet_in;
    logic [255:0] u_data;
    logic [63:0]  u_dstaddr;
    logic [63:0]  u_srcaddr;
    logic [7:0]   cmd_opcode;
    logic [3:0]   cmd_size;
    logic [19:0]  cmd_user;
    logic cmd_write, cmd_read, cmd_atomic, cmd_invalid;
    logic cmd_write_normal, cmd_write_response, cmd_write_signal;
    logic cmd_write_stream, cmd_write_ack;
    logic cmd_atomic_swap, cmd_atomic_add, cmd_atomic_and, cmd_atomic_or;
    logic cmd_atomic_xor, cmd_atomic_min, cmd_atomic_max;

    always #5 clk = ~clk;

    umi_packet_codec dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .size               (size),
        .user               (user),
        .burst              (burst),
        .dstaddr            (dstaddr),
        .srcaddr            (srcaddr),
        .data               (data),
        .packet_out         (packet_out),
        .packet_in          (packet_in),
        .u_data             (u_data),
        .u_dstaddr          (u_dstaddr),
        .u_srcaddr          (u_srcaddr),
        .cmd_opcode         (cmd_opcode),
        .cmd_size           (cmd_size),
        .cmd_user           (cmd_user),
        .cmd_write          (cmd_write),
        .cmd_read           (cmd_read),
        .cmd_atomic         (cmd_atomic),
        .cmd_invalid        (cmd_invalid),
        .cmd_write_normal   (cmd_write_normal),
        .cmd_write_response (cmd_write_response),
        .cmd_write_signal   (cmd_write_signal),
        .cmd_write_stream   (cmd_write_stream),
        .cmd_write_ack      (cmd_write_ack),
        .cmd_atomic_swap    (cmd_atomic_swap),
        .cmd_atomic_add     (cmd_atomic_add),
        .cmd_atomic_and     (cmd_atomic_and),
        .cmd_atomic_or      (cmd_atomic_or),
        .cmd_atomic_xor     (cmd_atomic_xor),
        .cmd_atomic_min     (cmd_atomic_min),
        .cmd_atomic_max     (cmd_atomic_max)
    );

    localparam logic [15:0] FW   = 16'h8000;
    localparam logic [15:0] FR   = 16'h4000;
    localparam logic [15:0] FA   = 16'h2000;
    localparam logic [15:0] FI   = 16'h1000;
    localparam logic [15:0] FWN  = 16'h0800;
    localparam logic [15:0] FWR  = 16'h0400;
    localparam logic [15:0] FWS  = 16'h0200;
    localparam logic [15:0] FWST = 16'h0100;
    localparam logic [15:0] FWA  = 16'h0080;
    localparam logic [15:0] FAS  = 16'h0040;
    localparam logic [15:0] FAA  = 16'h0020;
    localparam logic [15:0] FAN  = 16'h0010;
    localparam logic [15:0] FAO  = 16'h0008;
    localparam logic [15:0] FAX  = 16'h0004;
    localparam logic [15:0] FAMI = 16'h0002;
    localparam logic [15:0] FAMA = 16'h0001;

    typedef struct {
        logic [7:0]  op;
        logic        burst;
        logic [15:0] flags;
    } vec_t;

    typedef struct {
        logic [255:0] pkt;
        logic [255:0] udata;
        logic [63:0]  udst;
        logic [63:0]  usrc;
        logic [31:0]  cmd;
        logic [15:0]  flags;
    } exp_t;

    localparam int NV = 26;
    vec_t vt [NV];
    exp_t sb [$];
    int total = 0;
    int bad = 0;

    function automatic logic [15:0] got_flags();
        return {cmd_write, cmd_read, cmd_atomic, cmd_invalid,
                cmd_write_normal, cmd_write_response, cmd_write_signal,
                cmd_write_stream, cmd_write_ack,
                cmd_atomic_swap, cmd_atomic_add, cmd_atomic_and,
                cmd_atomic_or, cmd_atomic_xor, cmd_atomic_min,
                cmd_atomic_max};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] pack_model(
        input logic [7:0] op, input logic [3:0] sz,
        input logic [19:0] us, input logic b,
        input logic [63:0] d, input logic [63:0] s,
        input logic [255:0] dt
    );
        if (b) return dt;
        return {dt[95:64], s[63:32], d[63:32], dt[63:32],
                dt[31:0], s[31:0], d[31:0], us, sz, op};
    endfunction

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic b,
                         input logic [255:0] pin);
        opcode    = 8'($urandom);
        size      = 4'($urandom);
        user      = 20'($urandom);
        burst     = b;
        dstaddr   = {$urandom, $urandom};
        srcaddr   = {$urandom, $urandom};
        data      = rnd256();
        packet_in = {pin[255:8], op};
    endtask

    task automatic push_exp(input logic [15:0] f);
        exp_t e;
        e.pkt   = pack_model(opcode, size, user, burst,
                             dstaddr, srcaddr, data);
        e.udata = {160'b0, packet_in[255:224], packet_in[159:96]};
        e.udst  = {packet_in[191:160], packet_in[63:32]};
        e.usrc  = {packet_in[223:192], packet_in[95:64]};
        e.cmd   = packet_in[31:0];
        e.flags = f;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=0 want=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pkt"}, packet_out, e.pkt);
            chk({tag, "_udata"}, u_data, e.udata);
            chk({tag, "_udst"}, 256'(u_dstaddr), 256'(e.udst));
            chk({tag, "_usrc"}, 256'(u_srcaddr), 256'(e.usrc));
            chk({tag, "_cmd"}, 256'({cmd_user, cmd_size, cmd_opcode}),
                256'(e.cmd));
            chk({tag, "_flags"}, 256'(got_flags()), 256'(e.flags));
        end
    endtask

    task automatic zero_inputs();
        opcode = '0; size = '0; user = '0; burst = 1'b0;
        dstaddr = '0; srcaddr = '0; data = '0; packet_in = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pkt"}, packet_out, '0);
        chk({tag, "_udata"}, u_data, '0);
        chk({tag, "_addr"}, 256'({u_dstaddr, u_srcaddr}), '0);
        chk({tag, "_cmd"}, 256'({cmd_user, cmd_size, cmd_opcode}), '0);
        chk({tag, "_flags"}, 256'(got_flags()), '0);
    endtask

    initial begin
        vt[0]  = '{8'h01, 1'b0, FW | FWN};
        vt[1]  = '{8'h03, 1'b0, FW | FWR};
        vt[2]  = '{8'h05, 1'b0, FW | FWS};
        vt[3]  = '{8'h07, 1'b0, FW | FWST};
        vt[4]  = '{8'h09, 1'b0, FW | FWA};
        vt[5]  = '{8'h0B, 1'b0, FW | FI};
        vt[6]  = '{8'h0D, 1'b0, FW | FI};
        vt[7]  = '{8'h0F, 1'b0, FW | FI};
        vt[8]  = '{8'h11, 1'b0, FW | FWN};
        vt[9]  = '{8'hFF, 1'b0, FW | FI};
        vt[10] = '{8'h02, 1'b0, FR};
        vt[11] = '{8'hF2, 1'b0, FR};
        vt[12] = '{8'h04, 1'b0, FA | FAS};
        vt[13] = '{8'h14, 1'b0, FA | FAA};
        vt[14] = '{8'h24, 1'b0, FA | FAN};
        vt[15] = '{8'h34, 1'b0, FA | FAO};
        vt[16] = '{8'h44, 1'b0, FA | FAX};
        vt[17] = '{8'h54, 1'b0, FA | FAMI};
        vt[18] = '{8'h64, 1'b0, FA | FAMA};
        vt[19] = '{8'h74, 1'b0, FA | FI};
        vt[20] = '{8'hF4, 1'b0, FA | FI};
        vt[21] = '{8'h00, 1'b0, FI};
        vt[22] = '{8'h06, 1'b0, FI};
        vt[23] = '{8'h08, 1'b0, FI};
        vt[24] = '{8'h03, 1'b1, FW | FWR};
        vt[25] = '{8'hA5, 1'b1, FW | FWS};

        rst = 1'b1;
        zero_inputs();
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        opcode  = 8'h01;
        size    = 4'd2;
        user    = 20'h0;
        burst   = 1'b0;
        dstaddr = 64'h1122334455667788;
        srcaddr = 64'h0;
        data    = 256'hDEADBEEF;
        step();
        chk("layout_cmd", 256'(packet_out[31:0]), 256'(32'h00000201));
        chk("layout_dlo", 256'(packet_out[63:32]), 256'(32'h55667788));
        chk("layout_dhi", 256'(packet_out[191:160]), 256'(32'h11223344));
        chk("layout_d0", 256'(packet_out[127:96]), 256'(32'hDEADBEEF));
        chk("op00_flags", 256'(got_flags()), 256'(FI));

        opcode  = 8'h01;
        size    = 4'd3;
        user    = 20'hABCDE;
        dstaddr = 64'h0123456789ABCDEF;
        srcaddr = 64'hCAFEF00D12345678;
        data    = {160'b0, 96'h0102030405060708090A0B0C};
        step();
        packet_in = packet_out;
        zero_inputs();
        packet_in = packet_out;
        chk("lb_lat_udst", 256'(u_dstaddr), 256'(64'h0));
        step();
        packet_in = '0;
        chk("lb_udst", 256'(u_dstaddr), 256'(64'h0123456789ABCDEF));
        chk("lb_usrc", 256'(u_srcaddr), 256'(64'hCAFEF00D12345678));
        chk("lb_udata", u_data,
            {160'b0, 96'h0102030405060708090A0B0C});
        chk("lb_cmd", 256'({cmd_user, cmd_size, cmd_opcode}),
            256'(32'hABCDE301));
        chk("lb_flags", 256'(got_flags()), 256'(FW | FWN));

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].op, vt[i].burst, rnd256());
            push_exp(vt[i].flags);
            step();
            pop_chk($sformatf("v%0d", i));
        end

        drive(8'h02, 1'b1, rnd256());
        data = {32{8'hA5}};
        step();
        chk("burst_a5", packet_out, {32{8'hA5}});

        drive(8'h01, 1'b0, rnd256());
        rst = 1'b1;
        step();
        chk_all_zero("midrst");
        rst = 1'b0;
        push_exp(FW | FWN);
        step();
        pop_chk("postrst");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain left=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
